// File: rtl/clock_div_multi_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_div_multi_pkg;

  // Reset-default period and high time (input cycles).
  localparam int DEF_DIV  = 10;
  localparam int DEF_HIGH = 5;

  // Channel-index width; at least one bit even for a single channel.
  function automatic int calc_ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A load is accepted only if it describes a real, non-degenerate clock
  // on an existing channel.
  function automatic logic load_ok(input int unsigned div,
                                   input int unsigned high,
                                   input int unsigned ch,
                                   input int unsigned nch);
    return (div >= 2) && (high >= 1) && (high < div) && (ch < nch);
  endfunction

endpackage

// File: rtl/clock_div_multi_ch.sv
// One divider channel: phase counter, active/shadow period registers and
// registered clock/tick outputs. Shadow values move to active only at a
// period boundary (wrap, sync, or while disabled) so outputs never glitch.
module clock_div_multi_ch
  import clock_div_multi_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_div,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pend
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] D_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] D_HIGH = CNT_W'(DEFAULT_HIGH);

  logic [CNT_W-1:0] r_p, r_div_a, r_high_a, r_div_s, r_high_s;
  logic             r_pend, r_clk, r_tick;

  logic [CNT_W-1:0] w_p_n, w_div_a_n, w_high_a_n;
  logic             w_last, w_apply, w_clk_n, w_tick_n;

  // Next phase and active values; outputs derive from next-state so the
  // flops show the level for the phase being entered.
  always_comb begin
    w_last     = (r_p == (r_div_a - ONE));
    w_apply    = r_pend & (~i_en | i_sync | w_last);
    w_div_a_n  = w_apply ? r_div_s  : r_div_a;
    w_high_a_n = w_apply ? r_high_s : r_high_a;
    if (!i_en)                w_p_n = w_div_a_n - ONE;
    else if (i_sync || w_last) w_p_n = '0;
    else                      w_p_n = r_p + ONE;
    w_clk_n  = i_en & (w_p_n < w_high_a_n);
    w_tick_n = i_en & (w_p_n == '0);
  end

  // Channel state; a load in the same edge as an apply lands in the
  // shadow after the old shadow has moved to active.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_p      <= D_DIV - ONE;
      r_div_a  <= D_DIV;
      r_high_a <= D_HIGH;
      r_div_s  <= D_DIV;
      r_high_s <= D_HIGH;
      r_pend   <= 1'b0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_p      <= w_p_n;
      r_div_a  <= w_div_a_n;
      r_high_a <= w_high_a_n;
      r_clk    <= w_clk_n;
      r_tick   <= w_tick_n;
      if (i_load) begin
        r_div_s  <= i_div;
        r_high_s <= i_high;
        r_pend   <= 1'b1;
      end else if (w_apply) begin
        r_pend   <= 1'b0;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_pend = r_pend;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: load decode, load-error flag
// and sync fan-out around an array of per-channel dividers.
module clock_div_multi
  import clock_div_multi_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int DEFAULT_HIGH = DEF_HIGH,
  localparam int CH_W        = calc_ch_w(NUM_CH)
) (
  input  logic              i_clk_in,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_ch_en,
  input  logic              i_sync_req,
  input  logic              i_div_load,
  input  logic [CH_W-1:0]   i_div_ch,
  input  logic [CNT_W-1:0]  i_div_value,
  input  logic [CNT_W-1:0]  i_high_value,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_tick_out,
  output logic [NUM_CH-1:0] o_pend_out,
  output logic              o_load_err
);

  logic              w_valid;
  logic [NUM_CH-1:0] w_ld;
  logic              r_load_err;

  assign w_valid = load_ok(32'(i_div_value), 32'(i_high_value),
                           32'(i_div_ch), NUM_CH);

  // Flag rejected loads for one cycle.
  always_ff @(posedge i_clk_in) begin
    if (i_reset) r_load_err <= 1'b0;
    else         r_load_err <= i_div_load & ~w_valid;
  end

  assign o_load_err = r_load_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ld[g] = i_div_load & w_valid & (i_div_ch == CH_W'(g));

    clock_div_multi_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_ch (
      .i_clk  (i_clk_in),
      .i_reset(i_reset),
      .i_en   (i_ch_en[g]),
      .i_sync (i_sync_req),
      .i_load (w_ld[g]),
      .i_div  (i_div_value),
      .i_high (i_high_value),
      .o_clk  (o_clk_out[g]),
      .o_tick (o_tick_out[g]),
      .o_pend (o_pend_out[g])
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Directed bench for clock_div_multi with three channels.
module tb_clock_div_multi;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 2;

  logic              clk;
  logic              i_reset;
  logic [NUM_CH-1:0] i_ch_en;
  logic              i_sync_req;
  logic              i_div_load;
  logic [CH_W-1:0]   i_div_ch;
  logic [CNT_W-1:0]  i_div_value;
  logic [CNT_W-1:0]  i_high_value;
  logic [NUM_CH-1:0] o_clk_out;
  logic [NUM_CH-1:0] o_tick_out;
  logic [NUM_CH-1:0] o_pend_out;
  logic              o_load_err;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  clock_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .i_clk_in    (clk),
    .i_reset     (i_reset),
    .i_ch_en     (i_ch_en),
    .i_sync_req  (i_sync_req),
    .i_div_load  (i_div_load),
    .i_div_ch    (i_div_ch),
    .i_div_value (i_div_value),
    .i_high_value(i_high_value),
    .o_clk_out   (o_clk_out),
    .o_tick_out  (o_tick_out),
    .o_pend_out  (o_pend_out),
    .o_load_err  (o_load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel ch at phase ph with high time hi.
  task automatic chk_ch(input string tag, input int ch, input int ph, input int hi);
    chk({tag, "_clk"},  32'(o_clk_out[ch]),  32'(ph < hi));
    chk({tag, "_tick"}, 32'(o_tick_out[ch]), 32'(ph == 0));
  endtask

  int dv[3] = '{1, 6, 4};
  int hv[3] = '{1, 6, 1};
  int cv[3] = '{0, 0, 3};

  initial begin
    i_reset = 1'b1; i_ch_en = '0; i_sync_req = 1'b0; i_div_load = 1'b0;
    i_div_ch = '0; i_div_value = '0; i_high_value = '0;
    step(); step();
    chk("rst_clk",  32'(o_clk_out),  0);
    chk("rst_tick", 32'(o_tick_out), 0);
    chk("rst_pend", 32'(o_pend_out), 0);
    chk("rst_err",  32'(o_load_err), 0);

    // Release: first enabled edge is phase 0.
    i_reset = 1'b0; i_ch_en = 3'b111;
    step(); k = 0;
    chk("first_tick", 32'(o_tick_out), 32'h7);
    for (int c = 0; c < 20; c++) begin
      chk_ch("t1_c0", 0, k % 10, 5);
      chk_ch("t1_c1", 1, k % 10, 5);
      step();
    end
    // k=20; load ch1 4/1 while at phase 3
    step(); step(); step();
    i_div_load = 1'b1; i_div_ch = 2'd1; i_div_value = 16'd4; i_high_value = 16'd1;
    step(); i_div_load = 1'b0;
    chk("t2_pend_rise", 32'(o_pend_out), 32'h2);
    for (int c = 0; c < 5; c++) step();
    chk("t2_pend_hold", 32'(o_pend_out), 32'h2);
    chk_ch("t2_c1_old", 1, 9, 5);
    step(); // k=30: ch1 starts 4-cycle period
    chk("t2_pend_clr", 32'(o_pend_out), 0);
    for (int c = 0; c < 12; c++) begin
      chk_ch("t2_c0", 0, k % 10, 5);
      chk_ch("t2_c1", 1, (k - 30) % 4, 1);
      step();
    end

    // k=42: rejected loads
    for (int a = 0; a < 3; a++) begin
      i_div_load = 1'b1; i_div_ch = CH_W'(cv[a]);
      i_div_value = CNT_W'(dv[a]); i_high_value = CNT_W'(hv[a]);
      step(); i_div_load = 1'b0;
      chk("t3_err_hi", 32'(o_load_err), 1);
      chk("t3_pend",   32'(o_pend_out), 0);
      chk_ch("t3_c0", 0, k % 10, 5);
      chk_ch("t3_c1", 1, (k - 30) % 4, 1);
      step();
      chk("t3_err_lo", 32'(o_load_err), 0);
    end

    // k=48: ch1 -> 7/3
    i_div_load = 1'b1; i_div_ch = 2'd1; i_div_value = 16'd7; i_high_value = 16'd3;
    step(); i_div_load = 1'b0;
    chk("t4_pend", 32'(o_pend_out), 32'h2);
    step(); // k=50
    chk("t4_pend_clr", 32'(o_pend_out), 0);
    for (int c = 0; c < 12; c++) begin
      chk_ch("t4_c0", 0, k % 10, 5);
      chk_ch("t4_c1", 1, (k - 50) % 7, 3);
      step();
    end
    // k=62: sync
    i_sync_req = 1'b1;
    step(); i_sync_req = 1'b0; // k=63
    chk("t4_sync_tick", 32'(o_tick_out), 32'h7);
    for (int c = 0; c < 22; c++) begin
      chk_ch("t4s_c0", 0, (k - 63) % 10, 5);
      chk_ch("t4s_c1", 1, (k - 63) % 7, 3);
      chk_ch("t4s_c2", 2, (k - 63) % 10, 5);
      step();
    end

    // k=85: ch0 phase 2 (high); disable for 5 edges
    i_ch_en = 3'b110;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t5_off_clk",  32'(o_clk_out[0]),  0);
      chk("t5_off_tick", 32'(o_tick_out[0]), 0);
      chk_ch("t5_c1", 1, (k - 63) % 7, 3);
    end
    i_ch_en = 3'b111;
    step(); // k=91
    chk_ch("t5_reen", 0, 0, 5);
    for (int c = 0; c < 9; c++) begin
      chk_ch("t5_c0", 0, (k - 91) % 10, 5);
      chk_ch("t5_c1b", 1, (k - 63) % 7, 3);
      step();
    end

    // k=100: ch0 at phase 9; load on its wrap edge
    i_div_load = 1'b1; i_div_ch = 2'd0; i_div_value = 16'd3; i_high_value = 16'd1;
    step(); i_div_load = 1'b0;
    chk_ch("t6_wrap", 0, 0, 5);
    chk("t6_pend", 32'(o_pend_out), 32'h1);
    step(); step(); // k=103, phase 2 of old period
    chk_ch("t6_old", 0, 2, 5);
    chk("t6_pend_hold", 32'(o_pend_out), 32'h1);
    i_reset = 1'b1;
    step();
    chk("t6_rst_clk",  32'(o_clk_out),  0);
    chk("t6_rst_tick", 32'(o_tick_out), 0);
    chk("t6_rst_pend", 32'(o_pend_out), 0);
    chk("t6_rst_err",  32'(o_load_err), 0);
    i_reset = 1'b0;
    step(); // k=105
    chk("t6_rel_tick", 32'(o_tick_out), 32'h7);
    for (int c = 0; c < 12; c++) begin
      chk_ch("t6_c0", 0, (k - 105) % 10, 5);
      chk_ch("t6_c1", 1, (k - 105) % 10, 5);
      chk("t6_pend0", 32'(o_pend_out), 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_div_multi.md
# clock_div_multi

Parametrised, multi-channel successor to the fixed 1 MHz→100 kHz divider. Generates NUM_CH independent divided clocks from one input clock, each with a runtime-programmable period and duty cycle. Divisor and duty updates are glitch-free: they are applied only at a period boundary. A global sync input phase-aligns all channels. It sits beside the clock input and feeds sensor-sampling and comms-rate logic with both clock-level and single-cycle tick outputs.

## Interface
- NUM_CH, 2: number of output channels (1..8).
- CNT_W, 16: divisor/phase counter width.
- DEFAULT_DIV, 10: period in input cycles after reset (≥2).
- DEFAULT_HIGH, 5: high cycles per period after reset (1..DEFAULT_DIV-1).

- CLK_IN  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CH_EN  in  NUM_CH  per-channel run enable.
- SYNC_REQ  in  1  one-cycle pulse; restarts all enabled channels at phase 0.
- DIV_LOAD  in  1  load strobe for DIV_CH/DIV_VALUE/HIGH_VALUE.
- DIV_CH  in  CH_W  target channel index.
- DIV_VALUE  in  CNT_W  new period, in input cycles.
- HIGH_VALUE  in  CNT_W  new high time, in input cycles.
- CLK_OUT  out  NUM_CH  divided clocks, registered.
- TICK_OUT  out  NUM_CH  one-cycle pulse at each period start, registered.
- PEND_OUT  out  NUM_CH  shadow value waiting to be applied.
- LOAD_ERR  out  1  one-cycle pulse when a load is rejected.

## Operation
- Per-channel state: phase p, active div_a/high_a, shadow div_s/high_s, pending flag.
- All outputs are flops. In any cycle where p = k: CLK_OUT = (k < high_a), TICK_OUT = (k == 0). Outputs are computed from next-state.
- Running (CH_EN=1): p advances 0..div_a-1 and wraps to 0.
  - At the wrap edge, if pending=1: div_a←div_s, high_a←high_s, pending←0. The new period starts at that phase 0.
- Disabled (CH_EN=0): p is held at div_a-1, CLK_OUT=0, TICK_OUT=0, and a pending shadow is applied at the next edge.
  - Re-enable: p→0 at the first edge where CH_EN=1 is sampled, so CLK_OUT=1 and TICK_OUT=1 in that cycle.
- SYNC_REQ sampled high: every enabled channel is forced to p=0 and applies any pending shadow on that edge. Disabled channels are unaffected.
- Load validity: DIV_VALUE ≥ 2, 1 ≤ HIGH_VALUE < DIV_VALUE, and DIV_CH < NUM_CH.
  - Valid load: write the shadow and set pending=1. A second load before application overwrites the shadow.
  - Invalid load: no state change; LOAD_ERR pulses high in the following cycle.
- Load and wrap (or SYNC) on the same edge for the same channel:
  - Active registers take the previous shadow if pending was set; otherwise they are unchanged.
  - The new load lands in the shadow, and pending ends at 1.
- Arithmetic: unsigned compares only. p never exceeds div_a-1, so there is no overflow.

## Timing
- Reset edge: every channel gets div_a=div_s=DEFAULT_DIV, high_a=high_s=DEFAULT_HIGH, p=DEFAULT_DIV-1, and pending=0.
  - All outputs are 0 while in reset: CLK_OUT, TICK_OUT, PEND_OUT, LOAD_ERR.
- First edge with RESET=0 and CH_EN=1: p=0, so CLK_OUT=1 and TICK_OUT=1. Reset therefore behaves as the end of a period.
- Reset mid-period overrides everything, including load, sync and pending.
- Load latency: PEND_OUT rises 1 cycle after DIV_LOAD. The new period takes effect at the next wrap, SYNC, or disabled edge.
- TICK_OUT spacing equals div_a cycles exactly. The high time is high_a cycles exactly; with div=2, high=1 the output is a 50 % clock.

## Structure
- Package clock_div_multi_pkg holds:
  - CH_W = max(1, $clog2(NUM_CH));
  - the validity-check function;
  - the reset-default constants.
- Sub-module clock_div_multi_ch holds one channel (phase counter, active/shadow registers, output flops) and is instantiated NUM_CH times.
- The top level holds only load decode, the LOAD_ERR flop, and the SYNC_REQ fan-out.

## Test plan
- Reset then CH_EN=all 1 → each channel's TICK_OUT fires every 10 cycles, CLK_OUT is high 5 / low 5, and the first tick comes 1 edge after reset release.
- Load ch1 DIV=4 HIGH=1 at p=3 → ch1 finishes its 10-cycle period with PEND_OUT[1]=1, then runs 1-high/3-low; ch0 is unchanged.
- Load DIV=1, then HIGH=6 with DIV=6, then DIV_CH=NUM_CH → LOAD_ERR pulses once per attempt, and periods and PEND_OUT are unchanged.
- Run ch0 at div 10 and ch1 at div 7, then pulse SYNC_REQ → both show TICK_OUT=1 on the same cycle, then continue at 10 and 7.
- Drop CH_EN[0] for 5 cycles mid-high → CLK_OUT[0]=0 on the next cycle; re-enabling gives CLK_OUT=1/TICK=1 on the first enabled edge.
- Load during the wrap edge, then assert RESET for 1 cycle mid-period → the load stays pending across the wrap; after reset, defaults are restored and PEND_OUT=0.
